// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer and its decode/host neighbours.
// The master side drives the strobes and the program-store write port.
interface fetch_seq_if #(
    parameter int PC_W = 4
);
    logic            i_pcincr;
    logic            i_load_mode;
    logic            i_prog_we;
    logic [PC_W-1:0] i_prog_addr;
    logic [2:0]      i_prog_data;
    logic [2:0]      o_instr;
    logic [2:0]      o_data_count;
    logic [PC_W-1:0] o_pc;
    logic            o_halt;

    modport master (
        output i_pcincr, i_load_mode, i_prog_we, i_prog_addr, i_prog_data,
        input  o_instr, o_data_count, o_pc, o_halt
    );

    modport slave (
        input  i_pcincr, i_load_mode, i_prog_we, i_prog_addr, i_prog_data,
        output o_instr, o_data_count, o_pc, o_halt
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch and 0-7 bit sequencer with host-loadable program store.
// Define FETCH_WRAP_EN to wrap the PC at the end of the store instead of halting.
module fetch_seq #(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    fetch_seq_if.slave bus
);
    localparam logic [0:0]      ST_RUN  = 1'b0;
    localparam logic [0:0]      ST_LOAD = 1'b1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);
    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};

    logic [2:0]      mem_q [PROG_DEPTH];
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      count_q, count_d;
    logic            halt_q, halt_d;
    logic [0:0]      state_s;
    logic [2:0]      instr_s;

    assign state_s = bus.i_load_mode;

    // Next-state for PC, bit counter and the sticky halt flag.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        halt_d  = halt_q;
        case (state_s)
            ST_LOAD: begin
                pc_d    = PC_ZERO;
                count_d = 3'd0;
                halt_d  = 1'b0;
            end
            ST_RUN: begin
                if (bus.i_pcincr) begin
                    count_d = 3'd0;
                    if (pc_q == PC_LAST) begin
`ifdef FETCH_WRAP_EN
                        pc_d   = PC_ZERO;
                        halt_d = 1'b0;
`else
                        pc_d   = pc_q;
                        halt_d = 1'b1;
`endif
                    end else if (halt_q) begin
                        pc_d = pc_q;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end else begin
                    count_d = count_q + 3'd1;
                    pc_d    = pc_q;
                end
            end
            default: begin
                pc_d    = PC_ZERO;
                count_d = 3'd0;
                halt_d  = 1'b0;
            end
        endcase
    end

    // State registers and program store; reset also wipes the program.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
            pc_q    <= PC_ZERO;
            count_q <= 3'd0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            halt_q  <= halt_d;
            if ((state_s == ST_LOAD) && bus.i_prog_we) begin
                mem_q[bus.i_prog_addr] <= bus.i_prog_data;
            end
        end
    end

    // Instruction read; NOP is presented while loading or halted.
    always_comb begin
        if ((state_s == ST_LOAD) || halt_q) begin
            instr_s = 3'b000;
        end else begin
            instr_s = mem_q[pc_q];
        end
    end

    assign bus.o_instr      = instr_s;
    assign bus.o_data_count = count_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_halt       = halt_q;
endmodule

// File: tb/tb_fetch_seq.sv
// Randomised and directed bench for fetch_seq against a behavioural model.
module tb_fetch_seq;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_seq_if #(.PC_W(PW)) bus ();

    fetch_seq #(.PROG_DEPTH(DEPTH), .PC_W(PW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    int  m_mem [DEPTH];
    int  m_pc;
    int  m_cnt;
    bit  m_halt;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_instr();
        if (bus.i_load_mode || m_halt) return 0;
        return m_mem[m_pc];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_pc = 0; m_cnt = 0; m_halt = 1'b0;
    endtask

    // Model of one rising edge, from the rules of the program sequencer.
    task automatic model_edge(input bit ld, input bit inc, input bit we, input int addr, input int data);
        if (ld) begin
            if (we) m_mem[addr] = data;
            m_pc = 0; m_cnt = 0; m_halt = 1'b0;
        end else if (inc) begin
            m_cnt = 0;
            if (m_pc == DEPTH - 1) begin
`ifdef FETCH_WRAP_EN
                m_pc = 0;
`else
                m_halt = 1'b1;
`endif
            end else if (!m_halt) begin
                m_pc = m_pc + 1;
            end
        end else begin
            m_cnt = (m_cnt + 1) % 8;
        end
    endtask

    task automatic drive(input bit ld, input bit inc, input bit we, input int addr, input int data);
        bus.i_load_mode = ld;
        bus.i_pcincr    = inc;
        bus.i_prog_we   = we;
        bus.i_prog_addr = addr[PW-1:0];
        bus.i_prog_data = data[2:0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(bus.i_load_mode, bus.i_pcincr, bus.i_prog_we, int'(bus.i_prog_addr), int'(bus.i_prog_data));
        #1;
    endtask

    task automatic step(input bit ld, input bit inc, input bit we, input int addr, input int data);
        drive(ld, inc, we, addr, data);
        tick();
    endtask

    // Asynchronous reset between clock edges, checked before any edge occurs.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pc", int'(bus.o_pc), 0);
        chk("rst_count", int'(bus.o_data_count), 0);
        chk("rst_instr", int'(bus.o_instr), 0);
        chk("rst_halt", int'(bus.o_halt), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pc", int'(bus.o_pc), m_pc);
            chk("count", int'(bus.o_data_count), m_cnt);
            chk("instr", int'(bus.o_instr), exp_instr());
            chk("halt", int'(bus.o_halt), int'(m_halt));
        end
    end

    initial begin
        bit mode;
        int guard;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        model_clear();
        #1;
        chk("init_pc", int'(bus.o_pc), 0);
        chk("init_count", int'(bus.o_data_count), 0);
        chk("init_instr", int'(bus.o_instr), 0);
        chk("init_halt", int'(bus.o_halt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Load program then run.
        step(1'b1, 1'b0, 1'b1, 0, 7);
        step(1'b1, 1'b0, 1'b1, 1, 5);
        step(1'b1, 1'b0, 1'b1, 2, 1);
        chk("load_forced_nop", int'(bus.o_instr), 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("first_run_instr", int'(bus.o_instr), 7);
        chk("first_run_count", int'(bus.o_data_count), 0);
        for (int i = 0; i < 7; i++) tick();
        chk("count_7", int'(bus.o_data_count), 7);
        tick();
        chk("count_wrap", int'(bus.o_data_count), 0);
        for (int i = 0; i < 7; i++) tick();
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("adv_pc", int'(bus.o_pc), 1);
        chk("adv_instr", int'(bus.o_instr), 5);
        chk("adv_count", int'(bus.o_data_count), 0);

        // Collision at pc=5 and ignored write in RUN.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("at_pc5", int'(bus.o_pc), 5);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        chk("coll_pc", int'(bus.o_pc), 0);
        chk("coll_instr", int'(bus.o_instr), 0);
        step(1'b0, 1'b0, 1'b1, 0, 6);
        chk("run_we_ignored", int'(bus.o_instr), 7);

        // End of program.
        guard = 0;
        while (m_pc != DEPTH - 1 && guard < 40) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            guard++;
        end
        chk("reach_last", int'(bus.o_pc), DEPTH - 1);
        step(1'b0, 1'b1, 1'b0, 0, 0);
`ifdef FETCH_WRAP_EN
        chk("wrap_pc", int'(bus.o_pc), 0);
        chk("wrap_instr", int'(bus.o_instr), 7);
        chk("wrap_halt", int'(bus.o_halt), 0);
`else
        chk("end_pc", int'(bus.o_pc), 15);
        chk("end_halt", int'(bus.o_halt), 1);
        chk("end_instr", int'(bus.o_instr), 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("halt_hold_pc", int'(bus.o_pc), 15);
`endif
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("load_clr_halt", int'(bus.o_halt), 0);

        // Back-to-back pcincr from pc=2.
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("b2b_start", int'(bus.o_pc), 2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            chk("b2b_pc", int'(bus.o_pc), 3 + i);
            chk("b2b_count", int'(bus.o_data_count), 0);
        end

        // Reset mid-run, then sweep the store for NOPs.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 0, 0);
            #1;
            chk("cleared_mem", int'(bus.o_instr), 0);
            step(1'b0, 1'b1, 1'b0, 0, 0);
        end

        // Randomised traffic with load bursts and occasional resets.
        mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if (c % 700 == 699) do_reset();
            step(mode, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
